// File: rtl/part_select_streamer.sv
// part_select_streamer: serialises a WORD_W-bit word into WORD_W/SLICE_W
// slices over valid/ready, LSB-first or MSB-first per word, with a live
// bit-select of the current slice.
// Optional feature: define PSEL_PARITY_EN to add the out_par port (^out_slice).
module part_select_streamer #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned SLICE_W = 4,
    localparam int unsigned N  = WORD_W / SLICE_W,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned BW = (SLICE_W > 1) ? $clog2(SLICE_W) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_msb_first,
    input  logic [BW-1:0]      bit_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic               out_bit,
    output logic               out_last,
    output logic [IW-1:0]      out_idx
`ifdef PSEL_PARITY_EN
    ,
    output logic               out_par
`endif
);

    localparam int unsigned OW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic                dir_q, dir_d;

    logic                stream;
    logic                last;
    logic                beat;
    logic [OW-1:0]       offset;
    logic [SLICE_W-1:0]  slice;
    logic                sel_bit;

    // Slice decode from the held word and current index.
    always_comb begin
        offset  = OW'(idx_q) * OW'(SLICE_W);
        slice   = word_q[offset +: SLICE_W];
        sel_bit = 1'b0;
        if (32'(bit_sel) < SLICE_W) begin
            sel_bit = slice[bit_sel];
        end
    end

    // Next-state, datapath update and handshake/output decode.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        stream    = (state_q == STREAM);
        last      = stream && (cnt_q == IDX_MAX);
        beat      = stream && out_ready;
        in_ready  = !stream || (beat && last);
        out_valid = stream;
        out_slice = '0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        out_idx   = '0;

        if (stream) begin
            out_slice = slice;
            out_bit   = sel_bit;
            out_last  = last;
            out_idx   = idx_q;
        end

        if (in_valid && in_ready) begin
            // A word accepted on the last beat reloads without a bubble.
            word_d  = in_data;
            dir_d   = in_msb_first;
            idx_d   = in_msb_first ? IDX_MAX : '0;
            cnt_d   = '0;
            state_d = STREAM;
        end else if (beat) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                idx_d = dir_q ? (idx_q - IW'(1)) : (idx_q + IW'(1));
                cnt_d = cnt_q + IW'(1);
            end
        end
    end

`ifdef PSEL_PARITY_EN
    // Parity of the presented slice, forced low when nothing is presented.
    always_comb begin
        out_par = stream & (^slice);
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word, index, counter and direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
        end
    end

endmodule

// File: tb/tb_part_select_streamer.sv
// Bench for part_select_streamer: queue-of-beats model plus directed
// literal checks (define PSEL_PARITY_EN to cover out_par).
module tb_part_select_streamer;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned SLICE_W = 4;
    localparam int unsigned N       = WORD_W / SLICE_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_msb_first;
    logic [1:0]  bit_sel;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_slice;
    logic        out_bit;
    logic        out_last;
    logic [1:0]  out_idx;
    logic        out_par;

    part_select_streamer #(.WORD_W(WORD_W), .SLICE_W(SLICE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .bit_sel      (bit_sel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_slice    (out_slice),
        .out_bit      (out_bit),
        .out_last     (out_last),
        .out_idx      (out_idx)
`ifdef PSEL_PARITY_EN
        ,
        .out_par      (out_par)
`endif
    );

`ifndef PSEL_PARITY_EN
    assign out_par = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s;
        logic [1:0] i;
        logic       l;
    } beat_t;

    beat_t      q[$];
    beat_t      nb;
    beat_t      hb;
    logic [3:0] seen_s[$];
    logic [1:0] seen_i[$];
    logic       seen_l[$];
    logic       seen_b[$];
    logic       seen_p[$];
    int         vectors = 0;
    int         errors  = 0;
    int         cyc     = 0;
    bit         last_acc = 0;
    bit         rdy_m;
    int         sidx;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: the stream of beats a word must produce, consumed one per accepted beat.
    always @(posedge clk) begin
        cyc++;
        last_acc = 0;
        if (rst_n) begin
            rdy_m = (q.size() == 0) || (q.size() == 1 && out_ready);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy_m) begin
                for (int k = 0; k < int'(N); k++) begin
                    sidx = in_msb_first ? (int'(N) - 1 - k) : k;
                    nb.s = 4'((in_data >> (4 * sidx)) & 16'hf);
                    nb.i = 2'(sidx);
                    nb.l = (k == int'(N) - 1);
                    q.push_back(nb);
                end
                last_acc = 1;
            end
        end else begin
            q.delete();
        end
    end

    always @(negedge rst_n) q.delete();

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        chk("in_ready", in_ready, (q.size() == 0) || (q.size() == 1 && out_ready));
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            hb = q[0];
            chk("out_slice", out_slice, hb.s);
            chk("out_idx", out_idx, hb.i);
            chk("out_last", out_last, hb.l);
            chk("out_bit", out_bit, hb.s[bit_sel]);
`ifdef PSEL_PARITY_EN
            chk("out_par", out_par, ^hb.s);
`endif
            if (out_ready) begin
                seen_s.push_back(out_slice);
                seen_i.push_back(out_idx);
                seen_l.push_back(out_last);
                seen_b.push_back(out_bit);
                seen_p.push_back(out_par);
            end
        end else begin
            chk("idle_slice", out_slice, 0);
            chk("idle_idx", out_idx, 0);
            chk("idle_last", out_last, 0);
            chk("idle_bit", out_bit, 0);
            chk("idle_par", out_par, 0);
        end
    end

    task automatic clear_seen();
        seen_s.delete(); seen_i.delete(); seen_l.delete();
        seen_b.delete(); seen_p.delete();
    endtask

    // Beat k of the literal expectations lives in the low-order field.
    task automatic check_seen(string tag, input logic [15:0] es, input logic [7:0] ei,
                              input logic [3:0] el, input logic [3:0] eb);
        chk({tag, "_beats"}, seen_s.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < seen_s.size()) begin
                chk({tag, "_slice"}, seen_s[k], es[4*k +: 4]);
                chk({tag, "_idx"}, seen_i[k], ei[2*k +: 2]);
                chk({tag, "_last"}, seen_l[k], el[k]);
                chk({tag, "_bit"}, seen_b[k], eb[k]);
            end
        end
    endtask

    // Offer a word and return #1 after the edge that accepts it.
    task automatic send(input logic [15:0] d, input logic msb);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data = d;
        in_msb_first = msb;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            done = last_acc;
        end
        if (!done) begin
            vectors++; errors++;
            $display("FAIL accept_timeout: word %0h not accepted", d);
        end
        in_valid = 1'b0;
        in_data = 16'hxxxx;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (q.size() != 0 && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        if (q.size() != 0) begin
            vectors++; errors++;
            $display("FAIL drain_timeout: %0d beats left", q.size());
        end
    endtask

    int         t0;
    logic [3:0] cbits;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0;
        bit_sel = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_slice", out_slice, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_idx", out_idx, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LSB-first, bit 3 selected
        clear_seen(); bit_sel = 2'd3;
        send(16'habcd, 1'b0);
        drain();
        check_seen("lsb", 16'habcd, 8'he4, 4'b1000, 4'b1111);
`ifdef PSEL_PARITY_EN
        for (int k = 0; k < 4 && k < seen_p.size(); k++) begin
            cbits = 4'b0101;
            chk("lsb_par", seen_p[k], cbits[k]);
        end
`endif
        @(negedge clk);
        chk("lsb_done_ready", in_ready, 1);
        @(posedge clk); #1;

        // MSB-first, bit 0 selected
        clear_seen(); bit_sel = 2'd0;
        send(16'habcd, 1'b1);
        drain();
        check_seen("msb", 16'hdcba, 8'h1b, 4'b1000, 4'b1010);

        // Backpressure on the second slice with a live bit-select sweep
        clear_seen(); bit_sel = 2'd0; cbits = 4'b1100;
        send(16'habcd, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("stall_slice", out_slice, 4'hc);
            chk("stall_idx", out_idx, 1);
            for (int b = 0; b < 4; b++) begin
                bit_sel = 2'(b); #0.5;
                chk("stall_bitsel", out_bit, cbits[b]);
            end
            bit_sel = 2'd0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        check_seen("stall", 16'habcd, 8'he4, 4'b1000, 4'b0101);

        // Back-to-back words, second offered during the last beat
        clear_seen();
        send(16'habcd, 1'b0);
        t0 = cyc;
        send(16'h1234, 1'b0);
        chk("b2b_cycles", cyc - t0, N);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_slice", out_slice, 4'h4);
        chk("b2b_idx", out_idx, 0);
        drain();
        chk("b2b_total", seen_s.size(), 8);

        // Reset in the middle of a word
        send(16'habcd, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_slice", out_slice, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("postrst_valid", out_valid, 0);
            chk("postrst_ready", in_ready, 1);
        end

        // Mixed orders under random backpressure, model-checked
        fork
            begin
                send(16'h5a3c, 1'b1);
                send(16'hf00f, 1'b0);
                send(16'h8421, 1'b1);
            end
            begin
                repeat (30) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    bit_sel = 2'($urandom_range(0, 3));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
